// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic lamp receiver: 2-bit phase codes,
//   3-bit lamp encodings {red,yellow,green}, the controller state enum and
//   the phase successor function used for sequence legality checks.
package traffic_pkg;

  // Phase codes: first letter is road A, second is road B.
  localparam logic [1:0] PH_RG = 2'b00;
  localparam logic [1:0] PH_GY = 2'b01;
  localparam logic [1:0] PH_YG = 2'b10;
  localparam logic [1:0] PH_YR = 2'b11;

  // Lamp encodings {red,yellow,green}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Legal successor of a phase; YR wraps back to RG.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return ph + 2'd1;
  endfunction

endpackage

// File: rtl/phase_lamp_decode.sv
// phase_lamp_decode
//   Purely combinational mapping from a phase code to the lamp pair.
//   The mapping never produces green on both roads.
// Ports:
//   code_i    [1:0]  phase code (RG/GY/YG/YR)
//   lamp_a_o  [2:0]  road A lamps {red,yellow,green}
//   lamp_b_o  [2:0]  road B lamps {red,yellow,green}
module phase_lamp_decode
  import traffic_pkg::*;
(
  input  logic [1:0] code_i,
  output logic [2:0] lamp_a_o,
  output logic [2:0] lamp_b_o
);

  always_comb begin
    lamp_a_o = LAMP_R;
    lamp_b_o = LAMP_R;
    case (code_i)
      PH_RG: begin lamp_a_o = LAMP_R; lamp_b_o = LAMP_G; end
      PH_GY: begin lamp_a_o = LAMP_G; lamp_b_o = LAMP_Y; end
      PH_YG: begin lamp_a_o = LAMP_Y; lamp_b_o = LAMP_G; end
      PH_YR: begin lamp_a_o = LAMP_Y; lamp_b_o = LAMP_R; end
      default: begin lamp_a_o = LAMP_R; lamp_b_o = LAMP_R; end
    endcase
  end

endmodule

// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver
//   Receives phase codes over a valid/ready handshake, checks that each new
//   code is the legal successor of the current one, holds each phase for a
//   minimum dwell and drives registered one-hot lamps for roads A and B.
//   An illegal sequence latches a fault and flashes yellow on both roads
//   until fault_clr, after which an all-red interval precedes normal running.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   phase_valid  phase_code is presented
//   phase_code   [1:0] phase code
//   phase_ready  code accepted this cycle when valid
//   fault_clr    one-cycle pulse, leaves the fault state
//   lamp_a       [2:0] road A lamps {red,yellow,green}
//   lamp_b       [2:0] road B lamps {red,yellow,green}
//   fault        illegal sequence latched
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phase_valid,
  input  logic [1:0] phase_code,
  output logic       phase_ready,
  input  logic       fault_clr,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault
);

  localparam int MAX_GY   = (MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW;
  localparam int MAX_HOLD = (MAX_GY > FLASH_HALF) ? MAX_GY : FLASH_HALF;
  localparam int CW       = $clog2(MAX_HOLD + 1);

  // Last dwell value before the next accept may happen.
  localparam logic [CW-1:0] GREEN_LAST  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(MIN_YELLOW - 1);
  localparam logic [CW-1:0] FLASH_LAST  = CW'(FLASH_HALF - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] flash_q, flash_d;
  logic [1:0]    cur_phase_q, cur_phase_d;
  logic          first_q, first_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic [2:0]    lamp_a_q, lamp_a_d;
  logic [2:0]    lamp_b_q, lamp_b_d;

  logic [2:0]    dec_lamp_a;
  logic [2:0]    dec_lamp_b;
  logic          xfer;
  logic          legal;
  logic          is_new;
  logic [CW-1:0] dwell_inc;
  logic [CW-1:0] dwell_last;

  phase_lamp_decode u_decode (
    .code_i   (phase_code),
    .lamp_a_o (dec_lamp_a),
    .lamp_b_o (dec_lamp_b)
  );

  assign xfer   = phase_valid && ready_q;
  // The first code after INIT is always legal and always treated as new,
  // so the all-red interval ends on it even if it equals the reset phase.
  assign legal  = first_q || (phase_code == cur_phase_q) ||
                  (phase_code == next_phase(cur_phase_q));
  assign is_new = first_q || (phase_code != cur_phase_q);

  // Saturating dwell increment.
  assign dwell_inc  = (dwell_q == {CW{1'b1}}) ? dwell_q : dwell_q + CW'(1);
  assign dwell_last = (cur_phase_q == PH_YR) ? YELLOW_LAST : GREEN_LAST;

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    flash_d     = flash_q;
    cur_phase_d = cur_phase_q;
    first_d     = first_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    lamp_a_d    = lamp_a_q;
    lamp_b_d    = lamp_b_q;

    case (state_q)
      INIT: begin
        lamp_a_d = LAMP_R;
        lamp_b_d = LAMP_R;
        if (dwell_q >= YELLOW_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
          dwell_d = '0;
          first_d = 1'b1;
        end else begin
          dwell_d = dwell_inc;
        end
      end

      RUN: begin
        if (xfer && !legal) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          ready_d  = 1'b1;
          lamp_a_d = LAMP_Y;
          lamp_b_d = LAMP_Y;
          flash_d  = '0;
        end else if (xfer && is_new) begin
          cur_phase_d = phase_code;
          lamp_a_d    = dec_lamp_a;
          lamp_b_d    = dec_lamp_b;
          dwell_d     = '0;
          ready_d     = 1'b0;
          first_d     = 1'b0;
        end else begin
          // Ready is judged on the incremented dwell so that the earliest
          // following accept lands exactly MIN_x cycles after the last one.
          // It stays high once set (covers the first-code window and holds).
          dwell_d = dwell_inc;
          ready_d = ready_q || (dwell_inc >= dwell_last);
        end
      end

      FAULT: begin
        if (fault_clr) begin
          state_d  = INIT;
          fault_d  = 1'b0;
          ready_d  = 1'b0;
          dwell_d  = '0;
          first_d  = 1'b1;
          flash_d  = '0;
          lamp_a_d = LAMP_R;
          lamp_b_d = LAMP_R;
        end else if (flash_q >= FLASH_LAST) begin
          flash_d  = '0;
          lamp_a_d = (lamp_a_q == LAMP_Y) ? LAMP_OFF : LAMP_Y;
          lamp_b_d = (lamp_b_q == LAMP_Y) ? LAMP_OFF : LAMP_Y;
        end else begin
          flash_d = flash_q + CW'(1);
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      dwell_q     <= '0;
      flash_q     <= '0;
      cur_phase_q <= PH_RG;
      first_q     <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lamp_a_q    <= LAMP_R;
      lamp_b_q    <= LAMP_R;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      flash_q     <= flash_d;
      cur_phase_q <= cur_phase_d;
      first_q     <= first_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lamp_a_q    <= lamp_a_d;
      lamp_b_q    <= lamp_b_d;
    end
  end

  assign phase_ready = ready_q;
  assign fault       = fault_q;
  assign lamp_a      = lamp_a_q;
  assign lamp_b      = lamp_b_q;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// tb_traffic_lamp_driver
//   Directed stimulus for traffic_lamp_driver (default parameters 8/3/4).
//   Each issued phase code pushes its expected lamps, fault flag and accept
//   spacing into a queue; a monitor pops an entry on every handshake and
//   checks the registered outputs one edge later.
module tb_traffic_lamp_driver;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       phase_valid = 1'b0;
  logic [1:0] phase_code = 2'b00;
  logic       fault_clr = 1'b0;
  logic       phase_ready;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;

  always #5 clk = ~clk;

  traffic_lamp_driver #(
    .MIN_GREEN  (8),
    .MIN_YELLOW (3),
    .FLASH_HALF (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_valid (phase_valid),
    .phase_code  (phase_code),
    .phase_ready (phase_ready),
    .fault_clr   (fault_clr),
    .lamp_a      (lamp_a),
    .lamp_b      (lamp_b),
    .fault       (fault)
  );

  typedef struct {
    logic [2:0] la;
    logic [2:0] lb;
    logic       flt;
    logic       chk_lamps;
    int         gap;   // expected edges since previous accept, -1 = don't care
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Lamps must never show green on both roads.
  always @(negedge clk) begin
    if (rst_n)
      chk("no_double_green", {31'd0, (lamp_a == LAMP_G) && (lamp_b == LAMP_G)}, 32'd0);
  end

  // Monitor: one popped expectation per handshake.
  initial begin : monitor
    exp_t e;
    int   last_acc;
    int   acc;
    last_acc = -1000;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && phase_valid === 1'b1 && phase_ready === 1'b1) begin
        acc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'd1, 32'd0);
          last_acc = acc;
        end else begin
          e = exp_q.pop_front();
          if (e.gap >= 0)
            chk({e.tag, "_gap"}, acc - last_acc, e.gap);
          last_acc = acc;
          @(posedge clk);
          #1;
          if (e.chk_lamps) begin
            chk({e.tag, "_lamp_a"}, {29'd0, lamp_a}, {29'd0, e.la});
            chk({e.tag, "_lamp_b"}, {29'd0, lamp_b}, {29'd0, e.lb});
          end
          chk({e.tag, "_fault"}, {31'd0, fault}, {31'd0, e.flt});
          $display("xfer %s at cycle %0d: lamp_a=%b lamp_b=%b fault=%b",
                   e.tag, acc, lamp_a, lamp_b, fault);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [2:0] ea, input logic [2:0] eb, input logic ef,
                          input logic el, input int gap, input string tag);
    exp_t e;
    e.la = ea; e.lb = eb; e.flt = ef; e.chk_lamps = el; e.gap = gap; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Present a code and hold it until the handshake completes (bounded).
  task automatic send(input logic [1:0] code, input logic [2:0] ea, input logic [2:0] eb,
                      input logic ef, input logic el, input int gap, input string tag);
    exp_t dropped;
    bit   done;
    done = 1'b0;
    push_exp(ea, eb, ef, el, gap, tag);
    phase_valid = 1'b1;
    phase_code  = code;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (phase_ready) done = 1'b1;
    end
    if (!done) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      dropped = exp_q.pop_back();
    end
    @(posedge clk);
    #2;
  endtask

  // All-red interval: ready low for three windows, then high, lamps red.
  task automatic init_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_ready_low"}, {31'd0, phase_ready}, 32'd0);
      chk({tag, "_lamp_a_red"}, {29'd0, lamp_a}, {29'd0, LAMP_R});
      chk({tag, "_lamp_b_red"}, {29'd0, lamp_b}, {29'd0, LAMP_R});
      tick(1);
    end
    chk({tag, "_ready_high"}, {31'd0, phase_ready}, 32'd1);
    chk({tag, "_still_red_a"}, {29'd0, lamp_a}, {29'd0, LAMP_R});
    chk({tag, "_still_red_b"}, {29'd0, lamp_b}, {29'd0, LAMP_R});
    chk({tag, "_fault_low"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    tick(3);
    chk("reset_lamp_a", {29'd0, lamp_a}, {29'd0, LAMP_R});
    chk("reset_lamp_b", {29'd0, lamp_b}, {29'd0, LAMP_R});
    chk("reset_ready", {31'd0, phase_ready}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    rst_n = 1'b1;
    init_check("init");

    // Full cycle with valid held, then wrap, hold and a hold-then-advance.
    send(PH_RG, LAMP_R, LAMP_G, 1'b0, 1'b1, -1, "rg_first");
    send(PH_GY, LAMP_G, LAMP_Y, 1'b0, 1'b1, 8, "gy");
    send(PH_YG, LAMP_Y, LAMP_G, 1'b0, 1'b1, 8, "yg");
    send(PH_YR, LAMP_Y, LAMP_R, 1'b0, 1'b1, 8, "yr");
    send(PH_RG, LAMP_R, LAMP_G, 1'b0, 1'b1, 3, "wrap_rg");
    send(PH_RG, LAMP_R, LAMP_G, 1'b0, 1'b1, 8, "hold_rg");
    chk("hold_keeps_ready", {31'd0, phase_ready}, 32'd1);
    send(PH_GY, LAMP_G, LAMP_Y, 1'b0, 1'b1, 1, "gy_after_hold");

    // Illegal 01 -> 11.
    send(PH_YR, LAMP_Y, LAMP_Y, 1'b1, 1'b1, 8, "illegal_yr");
    phase_valid = 1'b0;
    chk("fault_ready", {31'd0, phase_ready}, 32'd1);
    tick(1);
    tick(2);
    chk("flash_on_a", {29'd0, lamp_a}, {29'd0, LAMP_Y});
    chk("flash_on_b", {29'd0, lamp_b}, {29'd0, LAMP_Y});
    tick(1);
    chk("flash_off_a", {29'd0, lamp_a}, {29'd0, LAMP_OFF});
    chk("flash_off_b", {29'd0, lamp_b}, {29'd0, LAMP_OFF});
    tick(4);
    chk("flash_on2_a", {29'd0, lamp_a}, {29'd0, LAMP_Y});
    chk("flash_on2_b", {29'd0, lamp_b}, {29'd0, LAMP_Y});
    send(PH_YG, LAMP_Y, LAMP_Y, 1'b1, 1'b1, -1, "fault_discard");
    phase_valid = 1'b0;

    // fault_clr wins over a same-cycle transfer.
    push_exp(LAMP_R, LAMP_R, 1'b0, 1'b1, -1, "clr_vs_xfer");
    fault_clr   = 1'b1;
    phase_valid = 1'b1;
    phase_code  = PH_RG;
    tick(1);
    fault_clr   = 1'b0;
    phase_valid = 1'b0;
    init_check("after_clr");
    send(PH_YG, LAMP_Y, LAMP_G, 1'b0, 1'b1, -1, "first_after_clr");
    phase_valid = 1'b0;

    // Asynchronous reset mid-RUN with dwell at 4.
    tick(4);
    chk("pre_rst_lamp_a", {29'd0, lamp_a}, {29'd0, LAMP_Y});
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lamp_a", {29'd0, lamp_a}, {29'd0, LAMP_R});
    chk("async_rst_lamp_b", {29'd0, lamp_b}, {29'd0, LAMP_R});
    chk("async_rst_ready", {31'd0, phase_ready}, 32'd0);
    chk("async_rst_fault", {31'd0, fault}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    init_check("after_async_rst");
    send(PH_GY, LAMP_G, LAMP_Y, 1'b0, 1'b1, -1, "first_after_rst");
    phase_valid = 1'b0;

    tick(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
- Receiving end of the 2-bit traffic phase code produced by the intersection next-state controller.
- Accepts phase codes over a valid/ready handshake and checks that each code is the legal successor.
- Enforces a minimum dwell per phase and drives one-hot red/yellow/green lamps for road A and road B.
- On an illegal sequence, latches a fault and flashes yellow on both roads until cleared.

Parameters:
- MIN_GREEN, 8: minimum cycles a phase containing a green lamp is held before the next code is accepted (>=2).
- MIN_YELLOW, 3: minimum cycles for phase YR and for the post-reset/post-clear all-red interval (>=2).
- FLASH_HALF, 4: cycles per half-period of the fault yellow flash (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- phase_valid  in  1  phase_code is presented.
- phase_code  in  2  encoded phase: 00 RG, 01 GY, 10 YG, 11 YR (first letter road A, second road B).
- phase_ready  out  1  block will accept phase_code this cycle.
- fault_clr  in  1  one-cycle pulse; leaves FAULT.
- lamp_a  out  3  road A lamps {red,yellow,green}, one-hot.
- lamp_b  out  3  road B lamps {red,yellow,green}, one-hot.
- fault  out  1  illegal sequence latched.

Behaviour:
- One clock. Reset is asynchronous and active-low; clock and reset ports are named clk and rst_n.
- All outputs are registered.
- Reset values: lamp_a=lamp_b=3'b100 (all red), phase_ready=0, fault=0, state=INIT, dwell=0, cur_phase=RG, first=1.
- States: INIT, RUN, FAULT.
- INIT:
  - All red.
  - dwell counts up from 0.
  - When dwell reaches MIN_YELLOW-1, go to RUN next cycle with phase_ready=1, dwell=0, first=1.
  - Lamps remain all red until the first accept.
- RUN handshake:
  - A transfer occurs when phase_valid && phase_ready.
  - Without phase_ready, phase_code is ignored; the sender holds it. This is not a fault.
- RUN legality:
  - When first=1, any code is legal.
  - Otherwise the legal codes are cur_phase (hold) or its successor: 00->01->10->11->00 (wrap).
- RUN, legal accept of a new code:
  - cur_phase updates; lamps reflect the new phase on the next edge (1-cycle latency).
  - dwell clears; phase_ready drops to 0 on the next cycle; first clears.
- RUN, legal accept of the same code (hold): no lamp change, dwell not cleared, phase_ready stays 1.
- Dwell rule:
  - phase_ready asserts once dwell >= MIN_GREEN-1 for codes 00/01/10, or >= MIN_YELLOW-1 for 11.
  - Result: the earliest next accept is exactly MIN_x cycles after the previous accept.
  - dwell saturates at its maximum and never wraps.
- Lamp decode: R=100, Y=010, G=001.
  - RG: A=R, B=G.
  - GY: A=G, B=Y.
  - YG: A=Y, B=G.
  - YR: A=Y, B=R.
  - lamp_a and lamp_b must never both be green.
- Illegal accept in RUN:
  - Next cycle: state=FAULT, fault=1, phase_ready=1, both lamps 010, flash counter=0.
  - cur_phase is not updated.
- FAULT:
  - Every FLASH_HALF cycles, both lamps toggle together between 010 and 000.
  - All transfers are accepted and discarded.
  - fault_clr: next cycle goes to INIT (all red, fault=0, phase_ready=0, dwell=0).
- Simultaneous events:
  - fault_clr in RUN or INIT is ignored.
  - fault_clr in FAULT wins over a same-cycle transfer.
- rst_n asserted mid-operation (any state) immediately forces the reset values.
- Counter width: $clog2(max(MIN_GREEN,MIN_YELLOW,FLASH_HALF)+1).

Decomposition:
- Shared package traffic_pkg holds:
  - phase code localparams PH_RG=2'b00, PH_GY=2'b01, PH_YG=2'b10, PH_YR=2'b11;
  - lamp encodings LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001, LAMP_OFF=3'b000;
  - a next_phase function;
  - the state enum {INIT, RUN, FAULT}.
- One natural sub-module: phase_lamp_decode, a combinational code-to-{lamp_a,lamp_b} mapping reused by monitors.

Test Plan:
- Reset release, phase_valid=0 -> lamps 100/100 and phase_ready=0 for 3 cycles, then phase_ready=1; lamps still 100/100.
- Send 00 then hold valid with 01 -> 00 accepted (lamps A=100, B=001 next cycle); 01 accepted exactly 8 cycles after the 00 accept; lamps become A=001, B=010.
- Full cycle 00,01,10,11,00 with valid held high -> accept spacing 8,8,8,3 cycles; B-green/A-green never coincide; wrap 11->00 legal, fault=0.
- After 01 is accepted, send 11 -> fault=1 next cycle, lamps 010/010, toggling to 000/000 every 4 cycles; further codes accepted with no lamp change.
- In FAULT, pulse fault_clr in the same cycle as a valid 00 transfer -> INIT: lamps 100/100, fault=0, phase_ready=0 for 3 cycles; first code after INIT (e.g. 10) accepted as legal.
- Mid-RUN (phase 10, dwell=4), drop rst_n asynchronously between edges -> outputs return to reset values immediately without waiting for clk; after release, INIT behaviour repeats.
